// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle controller and the datapath decoder:
// state encoding, opcode constants and ALU operation codes.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;

  function automatic logic op_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts cycles without mem_ready_i and flags a timeout
// in the cycle whose increment would bring the count to MEM_WAIT_MAX.
module mc_wait_timer #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic timeout_o
);

  localparam int W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [W-1:0] LAST = W'(MEM_WAIT_MAX - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Ready in the final cycle suppresses inc_i, so ready wins the tie.
  assign timeout_o = inc_i && (cnt_q == LAST);

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle CPU control FSM: registered state/flags/retire counter,
// combinational strobes decoded from state, latched opcode and handshakes.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic [6:0]       opcode_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             mem_iord_o,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic             pc_src_o,
  output logic             reg_we_o,
  output logic             alu_src_o,
  output logic             mem_to_reg_o,
  output logic [1:0]       alu_op_o,
  output logic [2:0]       state_o,
  output logic             illegal_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] instret_o
);

  state_e           state_q, state_d;
  logic [6:0]       opcode_q;
  logic [CNT_W-1:0] instret_q;
  logic             illegal_q, timeout_q;
  logic             retire, wait_clr, wait_inc, wait_to;
  logic             is_load, is_store;

  assign is_load  = (opcode_q == OP_LOAD);
  assign is_store = (opcode_q == OP_STORE);

  assign wait_inc = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready_i;
  assign wait_clr = (state_d != state_q) &&
                    ((state_d == ST_FETCH) || (state_d == ST_MEM));

  mc_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_wait_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (wait_clr),
    .inc_i     (wait_inc),
    .timeout_o (wait_to)
  );

  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_iord_o   = 1'b0;
    ir_we_o      = 1'b0;
    pc_we_o      = 1'b0;
    pc_src_o     = 1'b0;
    reg_we_o     = 1'b0;
    alu_src_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_op_o     = ALU_ADD;
    case (state_q)
      ST_IDLE: begin
        if (run_i) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          ir_we_o = 1'b1;
          state_d = ST_DECODE;
        end else if (wait_to) begin
          state_d = ST_ERR;
        end
      end
      ST_DECODE: begin
        state_d = op_legal(opcode_i) ? ST_EXEC : ST_ERR;
      end
      ST_EXEC: begin
        case (opcode_q)
          OP_R: begin
            alu_op_o = ALU_R;
            state_d  = ST_WB;
          end
          OP_I: begin
            alu_op_o  = ALU_I;
            alu_src_o = 1'b1;
            state_d   = ST_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_o = 1'b1;
            state_d   = ST_MEM;
          end
          OP_BRANCH: begin
            alu_op_o = ALU_BR;
            pc_we_o  = 1'b1;
            pc_src_o = zero_i;
            retire   = 1'b1;
          end
          default: state_d = ST_ERR;
        endcase
      end
      ST_MEM: begin
        mem_req_o  = 1'b1;
        mem_iord_o = 1'b1;
        alu_src_o  = 1'b1;
        mem_we_o   = is_store;
        if (mem_ready_i) begin
          if (is_store) begin
            pc_we_o = 1'b1;
            retire  = 1'b1;
          end else begin
            state_d = ST_WB;
          end
        end else if (wait_to) begin
          state_d = ST_ERR;
        end
      end
      ST_WB: begin
        reg_we_o     = 1'b1;
        mem_to_reg_o = is_load;
        pc_we_o      = 1'b1;
        retire       = 1'b1;
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
    // run_i is only consulted here, at the instruction boundary.
    if (retire) state_d = run_i ? ST_FETCH : ST_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      opcode_q  <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) begin
        opcode_q <= opcode_i;
        if (!op_legal(opcode_i)) illegal_q <= 1'b1;
      end
      if (retire)  instret_q <= instret_q + 1'b1;
      if (wait_to) timeout_q <= 1'b1;
    end
  end

  assign state_o   = state_q;
  assign illegal_o = illegal_q;
  assign timeout_o = timeout_q;
  assign instret_o = instret_q;

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter MEM_WAIT_MAX, default 15: maximum cycles a memory request waits for mem_ready_i before a timeout.
REQ-002 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  reset, asynchronous assert, active-high.
REQ-005 run_i  in  1  run enable; sampled only at instruction boundaries.
REQ-006 opcode_i  in  7  instruction opcode field from the instruction register.
REQ-007 zero_i  in  1  ALU zero flag.
REQ-008 mem_ready_i  in  1  memory acknowledge for the current request.
REQ-009 mem_req_o  out  1  memory request strobe.
REQ-010 mem_we_o  out  1  memory write (store).
REQ-011 mem_iord_o  out  1  address select: 0 = PC (instruction), 1 = ALU result (data).
REQ-012 ir_we_o  out  1  instruction register load.
REQ-013 pc_we_o  out  1  PC update.
REQ-014 pc_src_o  out  1  next-PC select: 0 = PC+4, 1 = branch target.
REQ-015 reg_we_o  out  1  register file write.
REQ-016 alu_src_o  out  1  ALU operand B: 0 = rs2, 1 = immediate.
REQ-017 mem_to_reg_o  out  1  writeback select: 0 = ALU, 1 = memory.
REQ-018 alu_op_o  out  2  00 add, 01 branch-compare, 10 R-type, 11 I-type.
REQ-019 state_o  out  3  current state encoding.
REQ-020 illegal_o, timeout_o  out  1 each  sticky error flags.
REQ-021 instret_o  out  CNT_W  count of retired instructions.

Function
REQ-022 States SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=6.
REQ-023 Supported opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011. All other opcodes are illegal.
REQ-024 IDLE: go to FETCH when run_i=1; all strobes 0.
REQ-025 FETCH: mem_req_o=1, mem_iord_o=0. When mem_ready_i=1: ir_we_o=1 in that same cycle, then go to DECODE.
REQ-026 DECODE: latch opcode_i into opcode_q. Illegal opcode goes to ERR with illegal_o=1; otherwise go to EXEC.
REQ-027 EXEC, R-type: alu_op=10, alu_src=0; go to WB.
REQ-028 EXEC, I-ALU: alu_op=11, alu_src=1; go to WB.
REQ-029 EXEC, LOAD or STORE: alu_op=00, alu_src=1; go to MEM.
REQ-030 EXEC, BRANCH: alu_op=01, alu_src=0, pc_we_o=1, pc_src_o=zero_i. The instruction retires.
REQ-031 MEM: mem_req_o=1, mem_iord_o=1, alu_op=00, alu_src=1, and mem_we_o=1 for STORE. On mem_ready_i, LOAD goes to WB. STORE asserts pc_we_o=1 with pc_src_o=0, and the instruction retires.
REQ-032 WB: reg_we_o=1, mem_to_reg_o=1 for LOAD, pc_we_o=1, pc_src_o=0. The instruction retires.
REQ-033 Retire cycle: instret_o increments by 1, wrapping modulo 2^CNT_W. The next state is FETCH if run_i=1, else IDLE.
REQ-034 Strobes SHALL be combinational in state, opcode_q, zero_i and mem_ready_i. State, opcode_q, counters and flags SHALL be registered.
REQ-035 A wait counter clears on entry to FETCH or MEM and increments each cycle while mem_ready_i=0.
REQ-036 Timeout: when the wait counter reaches MEM_WAIT_MAX with mem_ready_i still 0, go to ERR with timeout_o=1. If mem_ready_i=1 in that same cycle, ready wins.
REQ-037 ERR: all strobes 0; remains in ERR until reset; error flags hold.
REQ-038 run_i deasserted mid-instruction SHALL NOT abort the instruction.
REQ-039 Each of pc_we_o, reg_we_o and ir_we_o SHALL assert for at most one cycle per instruction.

Reset
REQ-040 On rst_i=1, immediately: state=IDLE, opcode_q=0, wait counter=0, instret_o=0, illegal_o=0, timeout_o=0, and all strobes 0, including when reset occurs mid-instruction or mid-request.
REQ-041 After rst_i falls, the first FETCH SHALL begin on the first edge with run_i=1.

Structure
REQ-042 A shared package holds the state enumeration, the opcode constants and the alu_op codes. The datapath decoder reuses the same package.
REQ-043 One sub-module, mc_wait_timer, SHALL implement the wait counter and timeout compare.

Verification
REQ-044 R-type 0110011 with mem_ready_i=1 every cycle -> states 1,2,3,5; reg_we_o for 1 cycle; instret_o=1 after 4 cycles.
REQ-045 LOAD with data ready delayed 3 cycles -> MEM lasts 4 cycles; WB has mem_to_reg_o=1; no timeout.
REQ-046 BRANCH, once with zero_i=1 and once with zero_i=0 -> pc_src_o=1 then 0 in EXEC; 3 states per instruction; reg_we_o is never asserted.
REQ-047 STORE with mem_ready_i held 0 for 15 cycles in MEM -> state_o=6, timeout_o=1; all strobes 0 until rst_i.
REQ-048 opcode 1111111 -> illegal_o=1, state ERR after DECODE. Then rst_i mid-FETCH of the next test -> all outputs 0 asynchronously; instret_o=0.
REQ-049 CNT_W=4 with 17 R-type instructions -> instret_o wraps to 1.
